// File: rtl/gf180mcu_fd_sc_mcu9t5v0__setn_seq.sv
// Sequencer that drives active-low SETN and a clock enable for a bank of set-able flops.
// Outputs are decoded from registered state only; REQ arriving mid-sequence merges into one pending run.
module gf180mcu_fd_sc_mcu9t5v0__setn_seq #(
  parameter int ASSERT_CYC = 2,
  parameter int RECOV_CYC  = 1,
  parameter int CNT_W      = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ,
  output logic SETN,
  output logic CKEN,
  output logic BUSY,
  output logic ACK
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ASSERT_CYC - 1);
  // R_LAST is never consulted when there is no recovery phase.
  localparam logic [CNT_W-1:0] R_LAST = (RECOV_CYC > 0) ? CNT_W'(RECOV_CYC - 1) : '0;
  localparam logic [1:0]       S_AFTER_ASSERT = (RECOV_CYC == 0) ? S_DONE : S_RECOVER;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (REQ) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (REQ) pend_d = 1'b1;
        if (cnt_q == A_LAST) state_d = S_AFTER_ASSERT;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      S_RECOVER: begin
        if (REQ) pend_d = 1'b1;
        if (cnt_q == R_LAST) state_d = S_DONE;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = (pend_q || REQ) ? S_ASSERT : S_IDLE;
      end
    endcase
    // No state loops to itself, so any change of state is an entry.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == S_ASSERT) pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign SETN = (state_q != S_ASSERT);
  assign CKEN = (state_q == S_IDLE) || (state_q == S_DONE);
  assign BUSY = (state_q != S_IDLE);
  assign ACK  = (state_q == S_DONE);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__setn_seq.sv
// Bench for the SETN sequencer: a default build and a no-recovery build share stimulus,
// both checked against a sequence-position model.
module tb_gf180mcu_fd_sc_mcu9t5v0__setn_seq;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic REQ = 1'b0;
  logic setn0, cken0, busy0, ack0;
  logic setn1, cken1, busy1, ack1;

  int checks = 0;
  int errors = 0;

  // Model: position within a sequence (-1 = idle), pending flag, per build.
  int p[2];
  int pend[2];
  int ra[2];
  localparam int A = 2;
  logic [3:0] obs0, obs1;
  int recover_seen1 = 0;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__setn_seq #(.ASSERT_CYC(2), .RECOV_CYC(1), .CNT_W(4)) dut0 (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .SETN(setn0), .CKEN(cken0), .BUSY(busy0), .ACK(ack0)
  );

  gf180mcu_fd_sc_mcu9t5v0__setn_seq #(.ASSERT_CYC(2), .RECOV_CYC(0), .CNT_W(4)) dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .SETN(setn1), .CKEN(cken1), .BUSY(busy1), .ACK(ack1)
  );

  // Expected {SETN,CKEN,BUSY,ACK} for a given sequence position.
  function automatic logic [3:0] exp_out(int pos, int r);
    if (pos < 0)     return 4'b1100;
    if (pos < A)     return 4'b0010;
    if (pos < A + r) return 4'b1010;
    return 4'b1111;
  endfunction

  task automatic step(input logic req, input logic rst);
    REQ = req;
    RST = rst;
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        p[k] = 0; pend[k] = 0;
      end else if (p[k] < 0) begin
        if (req) p[k] = 0;
      end else if (p[k] == A + ra[k]) begin
        if (pend[k] != 0 || req) begin p[k] = 0; pend[k] = 0; end
        else p[k] = -1;
      end else begin
        if (req) pend[k] = 1;
        p[k] = p[k] + 1;
      end
    end
    #1;
    obs0 = {setn0, cken0, busy0, ack0};
    obs1 = {setn1, cken1, busy1, ack1};
    if (obs1 == 4'b1010) recover_seen1++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    checks++;
    if (obs0 !== 4'b0010) begin errors++; $display("FAIL reset_hold got %b want 0010", obs0); end
    // R0..R3 after release: ASSERT, RECOVER, DONE, IDLE
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs0 !== exp_out(p[0], ra[0])) begin
        errors++; $display("FAIL reset_rel%0d got %b want %b", i, obs0, exp_out(p[0], ra[0]));
      end
      checks++;
      if (obs1 !== exp_out(p[1], ra[1])) begin
        errors++; $display("FAIL reset_rel_r0_%0d got %b want %b", i, obs1, exp_out(p[1], ra[1]));
      end
    end
    checks++;
    if (obs0 !== 4'b1100) begin errors++; $display("FAIL reset_idle got %b want 1100", obs0); end
  endtask

  task automatic test_single();
    logic [3:0] want0 [5];
    want0 = '{4'b0010, 4'b0010, 4'b1010, 4'b1111, 4'b1100};
    for (int i = 0; i < 5; i++) begin
      step(i == 0, 1'b0);
      checks++;
      if (obs0 !== want0[i]) begin
        errors++; $display("FAIL single_E%0d got %b want %b", i, obs0, want0[i]);
      end
      checks++;
      if (obs1 !== exp_out(p[1], ra[1])) begin
        errors++; $display("FAIL single_r0_E%0d got %b want %b", i, obs1, exp_out(p[1], ra[1]));
      end
      // No-recovery build acknowledges one cycle earlier.
      if (i == 2) begin
        checks++;
        if (ack1 !== 1'b1) begin errors++; $display("FAIL single_r0_ack got %b want 1", ack1); end
      end
    end
  endtask

  task automatic test_merged();
    int acks = 0;
    int busy_low = 0;
    for (int i = 0; i < 9; i++) begin
      step(i < 3, 1'b0);
      if (ack0) acks++;
      if (i < 8 && !busy0) busy_low++;
      checks++;
      if (obs0 !== exp_out(p[0], ra[0])) begin
        errors++; $display("FAIL merged_c%0d got %b want %b", i, obs0, exp_out(p[0], ra[0]));
      end
    end
    checks++;
    if (acks != 2) begin errors++; $display("FAIL merged_acks got %0d want 2", acks); end
    checks++;
    if (busy_low != 0) begin errors++; $display("FAIL merged_busy got %0d idle cycles want 0", busy_low); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL merged_end_busy got %b want 0", busy0); end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0);   // E: enter ASSERT
    step(1'b1, 1'b0);   // request while asserting sets pending
    step(1'b1, 1'b1);   // reset on the edge that would enter RECOVER
    checks++;
    if (obs0 !== 4'b0010) begin errors++; $display("FAIL rstmid_hit got %b want 0010", obs0); end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs0 !== exp_out(p[0], ra[0])) begin
        errors++; $display("FAIL rstmid_c%0d got %b want %b", i, obs0, exp_out(p[0], ra[0]));
      end
    end
    // Pending request must have been discarded by reset.
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_pend got busy %b want 0", busy0); end
  endtask

  task automatic test_back_to_back();
    int low = 0;
    int idle = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      if (!setn0) low++;
      if (!busy0) idle++;
      checks++;
      if (obs0 !== exp_out(p[0], ra[0])) begin
        errors++; $display("FAIL b2b_c%0d got %b want %b", i, obs0, exp_out(p[0], ra[0]));
      end
    end
    checks++;
    if (low != 10) begin errors++; $display("FAIL b2b_setn_low got %0d want 10", low); end
    checks++;
    if (idle != 0) begin errors++; $display("FAIL b2b_idle got %0d want 0", idle); end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) == 0, ($urandom % 40) == 0);
      checks++;
      if (obs0 !== exp_out(p[0], ra[0])) begin
        errors++; $display("FAIL rand0_c%0d got %b want %b", i, obs0, exp_out(p[0], ra[0]));
      end
      checks++;
      if (obs1 !== exp_out(p[1], ra[1])) begin
        errors++; $display("FAIL rand1_c%0d got %b want %b", i, obs1, exp_out(p[1], ra[1]));
      end
    end
    checks++;
    if (recover_seen1 != 0) begin
      errors++; $display("FAIL r0_recover got %0d cycles want 0", recover_seen1);
    end
  endtask

  initial begin
    ra[0] = 1; ra[1] = 0;
    p[0] = -1; p[1] = -1; pend[0] = 0; pend[1] = 0;
    test_reset();
    test_single();
    test_merged();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
